// File: rtl/sva_attempt_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sva_attempt_sched_if                                                       |
// | Start/done, evaluator handshake and status bundle for sva_attempt_sched.   |
// | Optional macro: SVA_SCHED_TIMESTAMP_EN adds res_valid / res_ts.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface sva_attempt_sched_if #(
    parameter int NUM_SLOTS = 4,
    parameter int STATE_W   = 4,
    parameter int CNT_W     = 16,
    parameter int TS_W      = 8
);
    localparam int SW = $clog2(NUM_SLOTS);

    logic               start;
    logic               busy;
    logic               done;
    logic               eval_req;
    logic [SW-1:0]      eval_slot;
    logic [STATE_W-1:0] eval_state;
    logic               eval_ack;
    logic [STATE_W-1:0] eval_next_state;
    logic               eval_next_active;
    logic               eval_succ;
    logic               eval_fail;
    logic [CNT_W-1:0]   succ_cnt;
    logic [CNT_W-1:0]   fail_cnt;
    logic [SW:0]        active_cnt;
    logic               overflow;
`ifdef SVA_SCHED_TIMESTAMP_EN
    logic               res_valid;
    logic [TS_W-1:0]    res_ts;

    modport slave (
        input  start, eval_ack, eval_next_state, eval_next_active, eval_succ, eval_fail,
        output busy, done, eval_req, eval_slot, eval_state, succ_cnt, fail_cnt,
               active_cnt, overflow, res_valid, res_ts
    );
    modport master (
        output start, eval_ack, eval_next_state, eval_next_active, eval_succ, eval_fail,
        input  busy, done, eval_req, eval_slot, eval_state, succ_cnt, fail_cnt,
               active_cnt, overflow, res_valid, res_ts
    );
`else
    wire logic [TS_W-1:0] unused_ts = '0;

    modport slave (
        input  start, eval_ack, eval_next_state, eval_next_active, eval_succ, eval_fail,
        output busy, done, eval_req, eval_slot, eval_state, succ_cnt, fail_cnt,
               active_cnt, overflow
    );
    modport master (
        output start, eval_ack, eval_next_state, eval_next_active, eval_succ, eval_fail,
        input  busy, done, eval_req, eval_slot, eval_state, succ_cnt, fail_cnt,
               active_cnt, overflow
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sva_attempt_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sva_attempt_sched                                                          |
// | Per-sample scheduler: re-evaluates live assertion attempts, then spawns.   |
// | Optional macro: SVA_SCHED_TIMESTAMP_EN (per-slot start timestamps).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sva_attempt_sched #(
    parameter int NUM_SLOTS = 4,
    parameter int STATE_W   = 4,
    parameter int CNT_W     = 16,
    parameter int TS_W      = 8
) (
    input  wire logic          gclk,
    input  wire logic          grst,
    sva_attempt_sched_if.slave bus
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int PW = SW + 1;
    localparam int CW = SW + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        REQ       = 3'd2,
        SPAWN     = 3'd3,
        SPAWN_REQ = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t             state_q;
    logic [NUM_SLOTS-1:0] active_q;
    logic [NUM_SLOTS-1:0] snap_q;
    logic [STATE_W-1:0] slot_st_q [NUM_SLOTS];
    logic [PW-1:0]      ptr_q;
    logic               busy_q;
    logic               done_q;
    logic               eval_req_q;
    logic               overflow_q;
    logic [SW-1:0]      eval_slot_q;
    logic [STATE_W-1:0] eval_state_q;
    logic [CNT_W-1:0]   succ_cnt_q;
    logic [CNT_W-1:0]   fail_cnt_q;

    logic               scan_hit, free_hit;
    logic [SW-1:0]      scan_idx, free_idx;
    logic [CW-1:0]      active_cnt_d;
    logic               ack, spawning;

    // Descending loops so the lowest qualifying index is the one that sticks.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (snap_q[i] && (PW'(i) >= ptr_q)) begin
                scan_hit = 1'b1;
                scan_idx = SW'(i);
            end
            if (!active_q[i]) begin
                free_hit = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    always_comb begin
        active_cnt_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active_cnt_d = active_cnt_d + CW'(active_q[i]);
        end
    end

    assign spawning = (state_q == SPAWN) || (state_q == SPAWN_REQ);
    assign ack      = bus.eval_ack && ((state_q == REQ) || spawning);

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_q      <= IDLE;
            active_q     <= '0;
            snap_q       <= '0;
            ptr_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            eval_req_q   <= 1'b0;
            overflow_q   <= 1'b0;
            eval_slot_q  <= '0;
            eval_state_q <= '0;
            succ_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_st_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        snap_q  <= active_q;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                // Spawn selection lives here so the spawn request issues one
                // cycle after the last scan; all writebacks are already in active_q.
                SCAN: begin
                    if (scan_hit) begin
                        eval_req_q   <= 1'b1;
                        eval_slot_q  <= scan_idx;
                        eval_state_q <= slot_st_q[scan_idx];
                        state_q      <= REQ;
                    end else if (free_hit) begin
                        eval_req_q   <= 1'b1;
                        eval_slot_q  <= free_idx;
                        eval_state_q <= '0;
                        state_q      <= SPAWN;
                    end else begin
                        overflow_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                REQ: begin
                    if (bus.eval_ack) begin
                        eval_req_q <= 1'b0;
                        ptr_q      <= PW'(eval_slot_q) + 1'b1;
                        state_q    <= SCAN;
                    end
                end
                SPAWN, SPAWN_REQ: begin
                    if (bus.eval_ack) begin
                        eval_req_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        state_q <= SPAWN_REQ;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (ack) begin
                if (bus.eval_next_active) begin
                    active_q[eval_slot_q]  <= 1'b1;
                    slot_st_q[eval_slot_q] <= bus.eval_next_state;
                end else begin
                    active_q[eval_slot_q] <= 1'b0;
                end
                if (bus.eval_fail) begin
                    if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + 1'b1;
                end else if (bus.eval_succ) begin
                    if (succ_cnt_q != '1) succ_cnt_q <= succ_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.eval_req   = eval_req_q;
    assign bus.eval_slot  = eval_slot_q;
    assign bus.eval_state = eval_state_q;
    assign bus.succ_cnt   = succ_cnt_q;
    assign bus.fail_cnt   = fail_cnt_q;
    assign bus.active_cnt = active_cnt_d;
    assign bus.overflow   = overflow_q;

`ifdef SVA_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0] sample_q;
    logic [TS_W-1:0] round_ts_q;
    logic [TS_W-1:0] slot_ts_q [NUM_SLOTS];

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            sample_q   <= '0;
            round_ts_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_ts_q[i] <= '0;
            end
        end else begin
            if ((state_q == IDLE) && bus.start) begin
                round_ts_q <= sample_q;
                sample_q   <= sample_q + 1'b1;
            end
            if (ack && spawning && bus.eval_next_active) begin
                slot_ts_q[eval_slot_q] <= round_ts_q;
            end
        end
    end

    // A spawn that resolves on its first evaluation reports the current sample.
    assign bus.res_valid = ack && (bus.eval_succ || bus.eval_fail);
    assign bus.res_ts    = spawning ? round_ts_q : slot_ts_q[eval_slot_q];
`else
    wire logic [TS_W-1:0] unused_ts = '0;
`endif
endmodule
`default_nettype wire
